anim_scheduler: RTL

Sequences the pet's sprite animations on the divided animation clock. It owns the frame counter and the animation selection that the frame-memory lookup blocks consume. It latches animation requests from the game logic and plays the idle loop when nothing is pending. When several requests are pending, it picks the next animation by fixed priority. It sits between the game-state logic and the display frame-memory mux, and it replaces the free-running per-animation step counters.

---
 rtl/pmo_anim_pkg.sv | 44 ++++
 rtl/anim_prio_enc.sv | 30 +++
 rtl/anim_scheduler.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pmo_anim_pkg.sv
// Shared types and constants for the pet animation scheduler.
//   anim_t          : animation identifiers as presented on anim_id
//   FRAMES          : frame count per animation, indexed by anim_t
//   REQ_*           : bit positions of each animation in the req/pending vectors
//   frame_count()   : frame count lookup with a safe fallback for unused codes
//   anim_req_mask() : one-hot pending bit that belongs to an animation
package pmo_anim_pkg;

    typedef enum logic [2:0] {
        AnimIdle  = 3'd0,
        AnimFeed  = 3'd1,
        AnimPlay  = 3'd2,
        AnimSleep = 3'd3,
        AnimAlert = 3'd4
    } anim_t;

    localparam int unsigned FRAMES [0:4] = '{2, 4, 6, 8, 3};

    localparam int unsigned REQ_FEED  = 0;
    localparam int unsigned REQ_PLAY  = 1;
    localparam int unsigned REQ_SLEEP = 2;
    localparam int unsigned REQ_ALERT = 3;

    function automatic int unsigned frame_count(anim_t a);
        if (a > AnimAlert) begin
            return 1;
        end
        return FRAMES[a];
    endfunction

    function automatic logic [3:0] anim_req_mask(anim_t a);
        logic [3:0] mask;
        mask = 4'b0000;
        case (a)
            AnimFeed:  mask[REQ_FEED]  = 1'b1;
            AnimPlay:  mask[REQ_PLAY]  = 1'b1;
            AnimSleep: mask[REQ_SLEEP] = 1'b1;
            AnimAlert: mask[REQ_ALERT] = 1'b1;
            default:   mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/anim_prio_enc.sv
// Fixed-priority selector over the pending request vector.
// Order is ALERT > SLEEP > FEED > PLAY (note FEED beats PLAY despite its lower bit).
//   pending in  4 : latched requests (bit map of pmo_anim_pkg::REQ_*)
//   anim    out   : selected animation, AnimIdle when nothing is pending
//   valid   out 1 : high when at least one request is pending
module anim_prio_enc
    import pmo_anim_pkg::*;
(
    input  logic [3:0] pending,
    output anim_t      anim,
    output logic       valid
);

    always_comb begin
        anim  = AnimIdle;
        valid = 1'b1;
        if (pending[REQ_ALERT]) begin
            anim = AnimAlert;
        end else if (pending[REQ_SLEEP]) begin
            anim = AnimSleep;
        end else if (pending[REQ_FEED]) begin
            anim = AnimFeed;
        end else if (pending[REQ_PLAY]) begin
            anim = AnimPlay;
        end else begin
            valid = 1'b0;
        end
    end

endmodule

// File: rtl/anim_scheduler.sv
// Sprite animation sequencer running on the divided animation clock.
// Latches requests, plays the two-frame idle loop when nothing is queued and
// runs each requested animation REPEAT times before picking the next one.
//   clk_23  in  1      : animation clock
//   rst     in  1      : synchronous active-high reset
//   req     in  4      : request levels (FEED, PLAY, SLEEP, ALERT)
//   hold    in  1      : freeze progress; requests still accumulate
//   cancel  in  1      : abort the running animation (wins over hold)
//   anim_id out 3      : current animation
//   step    out STEP_W : frame index within anim_id
//   playing out 1      : non-idle animation running
//   done    out 1      : one-cycle pulse on normal completion
//   pending out 4      : latched, not-yet-served requests
module anim_scheduler
    import pmo_anim_pkg::*;
#(
    parameter int unsigned REPEAT = 2,
    parameter int unsigned STEP_W = 4
) (
    input  logic              clk_23,
    input  logic              rst,
    input  logic [3:0]        req,
    input  logic              hold,
    input  logic              cancel,
    output logic [2:0]        anim_id,
    output logic [STEP_W-1:0] step,
    output logic              playing,
    output logic              done,
    output logic [3:0]        pending
);

    typedef enum logic [0:0] {StIdle, StRun} state_t;

    state_t            state_q, state_d;
    anim_t             anim_q, anim_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [1:0]        rep_q, rep_d;
    logic              done_q, done_d;
    logic [3:0]        pend_q, pend_d;

    anim_t             sel_anim;
    logic              sel_valid;
    logic              launch;
    logic              last_step;
    logic              last_rep;

    anim_prio_enc u_prio (
        .pending (pend_q),
        .anim    (sel_anim),
        .valid   (sel_valid)
    );

    assign last_step = (step_q == STEP_W'(frame_count(anim_q) - 1));
    assign last_rep  = (rep_q == 2'(REPEAT - 1));

    always_comb begin
        state_d = state_q;
        anim_d  = anim_q;
        step_d  = step_q;
        rep_d   = rep_q;
        done_d  = 1'b0;
        pend_d  = pend_q | req;
        launch  = 1'b0;

        if (state_q == StRun && cancel) begin
            state_d = StIdle;
            anim_d  = AnimIdle;
            step_d  = '0;
            rep_d   = '0;
        end else if (!hold) begin
            unique case (state_q)
                StIdle: begin
                    // ALERT jumps the idle loop; others wait for the loop to wrap.
                    if (pend_q[REQ_ALERT] || (step_q == STEP_W'(1) && sel_valid)) begin
                        launch = 1'b1;
                    end else begin
                        step_d = (step_q == '0) ? STEP_W'(1) : '0;
                    end
                end
                StRun: begin
                    if (!last_step) begin
                        step_d = step_q + STEP_W'(1);
                    end else if (!last_rep) begin
                        step_d = '0;
                        rep_d  = rep_q + 2'd1;
                    end else begin
                        done_d = 1'b1;
                        if (sel_valid) begin
                            launch = 1'b1;
                        end else begin
                            state_d = StIdle;
                            anim_d  = AnimIdle;
                            step_d  = '0;
                            rep_d   = '0;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (launch) begin
            state_d = StRun;
            anim_d  = sel_anim;
            step_d  = '0;
            rep_d   = '0;
            // A fresh request for the launched bit re-queues it.
            pend_d  = (pend_q & ~anim_req_mask(sel_anim)) | req;
        end
    end

    always_ff @(posedge clk_23) begin
        if (rst) begin
            state_q <= StIdle;
            anim_q  <= AnimIdle;
            step_q  <= '0;
            rep_q   <= '0;
            done_q  <= 1'b0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            anim_q  <= anim_d;
            step_q  <= step_d;
            rep_q   <= rep_d;
            done_q  <= done_d;
            pend_q  <= pend_d;
        end
    end

    assign anim_id = anim_q;
    assign step    = step_q;
    assign playing = (state_q == StRun);
    assign done    = done_q;
    assign pending = pend_q;

endmodule
